// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP register slave: bus addresses, CTRL bit map, FSM states.
package mlp_pkg;

    localparam logic [1:0] ADDR_CTRL        = 2'd0;
    localparam logic [1:0] ADDR_INPUT_FIFO  = 2'd1;
    localparam logic [1:0] ADDR_WEIGHT_FIFO = 2'd2;
    localparam logic [1:0] ADDR_OUTPUT      = 2'd3;

    localparam int unsigned CTRL_RUN_BIT       = 0;
    localparam int unsigned CTRL_DONE_BIT      = 1;
    localparam int unsigned CTRL_ERR_BIT       = 2;
    localparam int unsigned CTRL_LAYER_SEL_BIT = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy
    } mlp_state_e;

endpackage

// File: rtl/mlp_param_bank.sv
// Sequential-load register bank: each write lands at the pointer, which then advances and wraps.
module mlp_param_bank #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   ptr_clr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [DEPTH*WIDTH-1:0] flat
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrW-1:0]        ptr_q;
    logic [DEPTH*WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            data_q <= '0;
        end else if (ptr_clr) begin
            ptr_q <= '0;
        end else if (wr_en) begin
            data_q[ptr_q*WIDTH +: WIDTH] <= wr_data;
            ptr_q <= (ptr_q == PtrW'(DEPTH - 1)) ? '0 : ptr_q + PtrW'(1);
        end
    end

    assign flat = data_q;

endmodule

// File: rtl/mlp_reg_slave.sv
// Host register front-end for the MLP core: parameter banks, CTRL/ERR/irq, start/done sequencing.
module mlp_reg_slave
    import mlp_pkg::*;
#(
    parameter int unsigned N_INPUTS  = 2,
    parameter int unsigned N_HIDDEN  = 4,
    parameter int unsigned N_OUTPUT  = 1,
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned WGT_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       write_en,
    input  logic [1:0]                                 addr,
    input  logic [31:0]                                writedata,
    output logic [31:0]                                readdata,
    output logic                                       irq,
    output logic                                       core_start,
    input  logic                                       core_done,
    input  logic [OUT_WIDTH-1:0]                       core_result,
    output logic [N_INPUTS*IN_WIDTH-1:0]               x_flat,
    output logic [N_HIDDEN*(N_INPUTS+1)*WGT_WIDTH-1:0] w1_flat,
    output logic [N_OUTPUT*(N_HIDDEN+1)*WGT_WIDTH-1:0] w2_flat
);
    localparam int unsigned W1Depth = N_HIDDEN * (N_INPUTS + 1);
    localparam int unsigned W2Depth = N_OUTPUT * (N_HIDDEN + 1);

    mlp_state_e           state_q;
    logic                 core_start_q, done_q, irq_q, err_q, layer_q;
    logic [OUT_WIDTH-1:0] result_q;
    logic [31:0]          readdata_q;

    logic busy, wr_ctrl, wr_in, wr_wgt, wr_out, run_req, new_layer;
    logic unused_wd;

    assign busy      = (state_q != StIdle);
    assign wr_ctrl   = write_en && (addr == ADDR_CTRL);
    assign wr_in     = write_en && (addr == ADDR_INPUT_FIFO);
    assign wr_wgt    = write_en && (addr == ADDR_WEIGHT_FIFO);
    assign wr_out    = write_en && (addr == ADDR_OUTPUT);
    assign new_layer = writedata[CTRL_LAYER_SEL_BIT];
    assign run_req   = wr_ctrl && writedata[CTRL_RUN_BIT] && !busy;
    assign unused_wd = ^writedata;

    mlp_param_bank #(.DEPTH(N_INPUTS), .WIDTH(IN_WIDTH)) u_x_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_in && !busy),
        .ptr_clr (1'b0),
        .wr_data (writedata[IN_WIDTH-1:0]),
        .flat    (x_flat)
    );

    // A layer switch rewinds only the bank being switched to.
    mlp_param_bank #(.DEPTH(W1Depth), .WIDTH(WGT_WIDTH)) u_w1_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_wgt && !busy && !layer_q),
        .ptr_clr (wr_ctrl && layer_q && !new_layer),
        .wr_data (writedata[WGT_WIDTH-1:0]),
        .flat    (w1_flat)
    );

    mlp_param_bank #(.DEPTH(W2Depth), .WIDTH(WGT_WIDTH)) u_w2_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_wgt && !busy && layer_q),
        .ptr_clr (wr_ctrl && !layer_q && new_layer),
        .wr_data (writedata[WGT_WIDTH-1:0]),
        .flat    (w2_flat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            result_q     <= '0;
        end else begin
            core_start_q <= 1'b0;
            if (wr_out) irq_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (run_req) begin
                        state_q      <= StStart;
                        core_start_q <= 1'b1;
                        done_q       <= 1'b0;
                        irq_q        <= 1'b0;
                    end
                end
                StStart: state_q <= StBusy;
                StBusy: begin
                    if (core_done) begin
                        result_q <= core_result;
                        done_q   <= 1'b1;
                        irq_q    <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ERR clear and set in the same write: the set wins, since that write was itself rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            layer_q <= 1'b0;
        end else begin
            if (wr_ctrl) layer_q <= new_layer;
            if (busy && (wr_in || wr_wgt || (wr_ctrl && writedata[CTRL_RUN_BIT]))) begin
                err_q <= 1'b1;
            end else if (wr_ctrl && writedata[CTRL_ERR_BIT]) begin
                err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readdata_q <= '0;
        end else begin
            case (addr)
                ADDR_CTRL:   readdata_q <= {28'd0, layer_q, err_q, done_q, busy};
                ADDR_OUTPUT: readdata_q <= {{(32-OUT_WIDTH){result_q[OUT_WIDTH-1]}}, result_q};
                default:     readdata_q <= '0;
            endcase
        end
    end

    assign readdata   = readdata_q;
    assign irq        = irq_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_mlp_reg_slave.sv
// Randomized scoreboard bench for mlp_reg_slave against a transaction-level register model.
module tb_mlp_reg_slave;
    logic        clk = 1'b0, rst_n = 1'b0, write_en = 1'b0, core_done = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] writedata = 32'd0;
    logic [15:0] core_result = 16'd0;
    logic [31:0] readdata;
    logic        irq, core_start;
    logic [31:0]  x_flat;
    logic [191:0] w1_flat;
    logic [79:0]  w2_flat;

    mlp_reg_slave dut (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .addr(addr), .writedata(writedata),
        .readdata(readdata), .irq(irq), .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [15:0] x_m [2];
    logic [15:0] w1_m [12];
    logic [15:0] w2_m [5];
    int xp, w1p, w2p;
    bit layer, err, done_m, irq_m, busy_m;
    logic [15:0] res_m;
    int starts_exp = 0, start_cnt = 0;
    logic [31:0] exp_q [$];
    bit rd_req = 1'b0, rd_chk = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) x_m[i] = 16'd0;
        for (int i = 0; i < 12; i++) w1_m[i] = 16'd0;
        for (int i = 0; i < 5; i++) w2_m[i] = 16'd0;
        xp = 0; w1p = 0; w2p = 0;
        layer = 0; err = 0; done_m = 0; irq_m = 0; busy_m = 0; res_m = 16'd0;
    endtask

    function automatic logic [31:0] expected_read(input logic [1:0] a);
        if (a == 2'd0) return {28'd0, layer, err, done_m, busy_m};
        if (a == 2'd3) return {{16{res_m[15]}}, res_m};
        return 32'd0;
    endfunction

    // Scoreboard monitor: readdata is valid one cycle after a read address is presented.
    always @(posedge clk) rd_chk <= rd_req;
    initial forever begin
        @(negedge clk);
        if (rd_chk) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL readdata: got %h with no expected entry", readdata);
            end else begin
                check("readdata", 256'(readdata), 256'(exp_q.pop_front()));
            end
        end
    end

    always @(posedge clk) if (core_start) start_cnt++;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        write_en = 1'b1; addr = a; writedata = d;
        @(negedge clk);
        write_en = 1'b0;
        case (a)
            2'd1: if (busy_m) err = 1; else begin x_m[xp] = d[15:0]; xp = (xp + 1) % 2; end
            2'd2: begin
                if (busy_m) err = 1;
                else if (!layer) begin w1_m[w1p] = d[15:0]; w1p = (w1p + 1) % 12; end
                else begin w2_m[w2p] = d[15:0]; w2p = (w2p + 1) % 5; end
            end
            2'd0: begin
                if (d[2]) err = 0;
                if (d[3] != layer) begin if (d[3]) w2p = 0; else w1p = 0; end
                layer = d[3];
                if (d[0]) begin
                    if (busy_m) err = 1;
                    else begin busy_m = 1; done_m = 0; irq_m = 0; starts_exp++; end
                end
            end
            default: irq_m = 0;
        endcase
    endtask

    task automatic bus_read(input logic [1:0] a);
        @(negedge clk);
        write_en = 1'b0; addr = a;
        exp_q.push_back(expected_read(a));
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] r);
        @(negedge clk);
        check("start_count", 256'(start_cnt), 256'(starts_exp));
        core_done = 1'b1; core_result = r;
        @(negedge clk);
        core_done = 1'b0;
        if (busy_m) begin res_m = r; done_m = 1; irq_m = 1; busy_m = 0; end
    endtask

    task automatic check_state();
        logic [31:0]  xe;
        logic [191:0] w1e;
        logic [79:0]  w2e;
        for (int i = 0; i < 2; i++) xe[i*16 +: 16] = x_m[i];
        for (int i = 0; i < 12; i++) w1e[i*16 +: 16] = w1_m[i];
        for (int i = 0; i < 5; i++) w2e[i*16 +: 16] = w2_m[i];
        check("x_flat", 256'(x_flat), 256'(xe));
        check("w1_flat", 256'(w1_flat), 256'(w1e));
        check("w2_flat", 256'(w2_flat), 256'(w2e));
        check("irq", 256'(irq), 256'(irq_m));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1;
        check("reset_readdata", 256'(readdata), 256'(0));
        check("reset_core_start", 256'(core_start), 256'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(2'd0);
        bus_read(2'd3);
        check_state();

        // Input FIFO: sign bits dropped to 16, third write wraps to entry 0.
        bus_write(2'd1, 32'd7);
        bus_write(2'd1, 32'hFFFF_FFFD);
        check("x_two_writes", 256'(x_flat), 256'(32'hFFFD_0007));
        bus_write(2'd1, 32'd5);
        check_state();

        for (int i = 1; i <= 12; i++) bus_write(2'd2, 32'(i));
        bus_write(2'd0, 32'h8);
        for (int i = 21; i <= 25; i++) bus_write(2'd2, 32'(i));
        check("w2_directed", 256'(w2_flat), 256'(80'h0019_0018_0017_0016_0015));
        check_state();

        // Run / done handshake.
        bus_write(2'd0, 32'h9);
        bus_read(2'd0);
        pulse_done(16'hFF80);
        bus_read(2'd0);
        bus_read(2'd3);
        check_state();
        bus_write(2'd3, 32'hDEAD_BEEF);
        check_state();
        bus_read(2'd0);

        // Writes while busy are rejected and flag ERR.
        bus_write(2'd0, 32'h9);
        bus_write(2'd1, 32'd9);
        bus_write(2'd0, 32'h9);
        check_state();
        bus_read(2'd0);
        pulse_done(16'h1234);
        bus_write(2'd0, 32'hC);
        bus_read(2'd0);

        // core_done while idle is ignored.
        pulse_done(16'h7777);
        bus_read(2'd3);
        bus_read(2'd0);
        check_state();

        for (int it = 0; it < 400; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: bus_write(2'd1, $urandom);
                2, 3: bus_write(2'd2, $urandom);
                4: bus_write(2'd0, $urandom & 32'hFFFF_FFFE);
                5: bus_write(2'd3, $urandom);
                6, 7: bus_read(2'($urandom_range(0, 3)));
                default: begin
                    int k;
                    bus_write(2'd0, {28'd0, layer, 3'b001});
                    k = int'($urandom_range(0, 3));
                    for (int j = 0; j < k; j++) begin
                        case ($urandom_range(0, 3))
                            0: bus_write(2'd1, $urandom);
                            1: bus_write(2'd2, $urandom);
                            2: bus_write(2'd0, {28'd0, layer, 3'b001});
                            default: bus_read(2'd0);
                        endcase
                    end
                    pulse_done(16'($urandom));
                    bus_read(2'd3);
                end
            endcase
            if (it % 8 == 0) check_state();
        end
        check_state();

        // Asynchronous reset while core_start is high and the FSM is running.
        bus_write(2'd0, {28'd0, layer, 3'b001});
        #2 rst_n = 1'b0;
        #1;
        check("rst_readdata", 256'(readdata), 256'(0));
        check("rst_irq", 256'(irq), 256'(0));
        check("rst_core_start", 256'(core_start), 256'(0));
        check("rst_x_flat", 256'(x_flat), 256'(0));
        check("rst_w1_flat", 256'(w1_flat), 256'(0));
        check("rst_w2_flat", 256'(w2_flat), 256'(0));
        starts_exp--;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(2'd0);
        bus_read(2'd3);
        check_state();

        repeat (3) @(negedge clk);
        check("final_start_count", 256'(start_cnt), 256'(starts_exp));
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
